// File: rtl/neopixel_driver.sv
// neopixel_driver
//   Holds NUM_PIXELS x {R,G,B} 8-bit levels and, on request, serializes the
//   frame onto a single WS2812 data wire with NRZ timing, followed by a
//   low latch gap.
//
// Ports:
//   clock, reset     system clock; asynchronous active-high reset
//   pixel_index[2:0] / color_index[1:0] / color_level[7:0] / load_color
//                    single-cycle write of one color byte (color 0=R,1=G,2=B)
//   send_it          single-cycle frame-transmit request
//   neo_data         registered serial line to the strip
//   ready_to_load / ready_to_send   high while idle
//
// Build option:
//   NEO_CLEAR_AFTER_SEND_EN  when defined, all color registers are zeroed on
//                            the LATCH->IDLE edge, so every frame must be
//                            reloaded. Undefined: registers persist.
module neopixel_driver #(
    parameter int NUM_PIXELS = 5,
    parameter int T0H_CYC    = 18,
    parameter int T1H_CYC    = 35,
    parameter int BIT_CYC    = 63,
    parameter int LATCH_CYC  = 2500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [2:0] pixel_index,
    input  logic [1:0] color_index,
    input  logic [7:0] color_level,
    input  logic       load_color,
    input  logic       send_it,
    output logic       neo_data,
    output logic       ready_to_load,
    output logic       ready_to_send
);

    localparam int CW = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int LW = (LATCH_CYC > 1) ? $clog2(LATCH_CYC) : 1;
    localparam logic [CW-1:0] BIT_LAST = CW'(BIT_CYC - 1);
    localparam logic [LW-1:0] LAT_LAST = LW'(LATCH_CYC - 1);
    localparam logic [2:0]    PIX_LAST = 3'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {S_IDLE, S_SEND, S_LATCH} state_t;

    state_t                         state_q, state_d;
    logic [CW-1:0]                  cyc_q, cyc_d;
    logic [4:0]                     bit_q, bit_d;   // 0..23 within a pixel
    logic [2:0]                     pix_q, pix_d;
    logic [LW-1:0]                  lat_q, lat_d;
    logic [NUM_PIXELS-1:0][2:0][7:0] col_q, col_d;  // [pixel][R,G,B]
    logic                           neo_q, neo_d;
    logic                           rdy_q, rdy_d;

    logic [7:0] cur_byte;
    logic [1:0] c_sel;
    logic       bit_val;

    always_comb begin
        state_d  = state_q;
        cyc_d    = cyc_q;
        bit_d    = bit_q;
        pix_d    = pix_q;
        lat_d    = lat_q;
        col_d    = col_q;
        neo_d    = 1'b0;
        rdy_d    = 1'b0;
        cur_byte = 8'h00;
        c_sel    = 2'd0;
        bit_val  = 1'b0;

        case (state_q)
            S_IDLE: begin
                rdy_d = 1'b1;
                // Only existing pixels and colors 0..2 match; anything else
                // falls through the loop and the write is dropped.
                if (load_color) begin
                    for (int p = 0; p < NUM_PIXELS; p++)
                        for (int c = 0; c < 3; c++)
                            if (int'(pixel_index) == p && int'(color_index) == c)
                                col_d[p][c] = color_level;
                end
                if (send_it) begin
                    state_d = S_SEND;
                    cyc_d   = '0;
                    bit_d   = 5'd0;
                    pix_d   = 3'd0;
                    rdy_d   = 1'b0;
                end
            end
            S_SEND: begin
                if (cyc_q == BIT_LAST) begin
                    cyc_d = '0;
                    if (bit_q == 5'd23) begin
                        bit_d = 5'd0;
                        if (pix_q == PIX_LAST) begin
                            pix_d   = 3'd0;
                            lat_d   = '0;
                            state_d = S_LATCH;
                        end else begin
                            pix_d = pix_q + 3'd1;
                        end
                    end else begin
                        bit_d = bit_q + 5'd1;
                    end
                end else begin
                    cyc_d = cyc_q + CW'(1);
                end
            end
            S_LATCH: begin
                if (lat_q == LAT_LAST) begin
                    lat_d   = '0;
                    state_d = S_IDLE;
                    rdy_d   = 1'b1;
`ifdef NEO_CLEAR_AFTER_SEND_EN
                    col_d   = '0;
`endif
                end else begin
                    lat_d = lat_q + LW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // neo_data is registered, so it is computed from the next-cycle
        // counters. Bits go out G,R,B per pixel, MSB first. col_q is used
        // rather than col_d: on the send edge the count is 0, where the line
        // is high whatever the bit, and a same-edge load lands in col_q
        // long before its bit is sampled.
        if (state_d == S_SEND) begin
            case (bit_d[4:3])
                2'd0:    c_sel = 2'd1;
                2'd1:    c_sel = 2'd0;
                default: c_sel = 2'd2;
            endcase
            for (int p = 0; p < NUM_PIXELS; p++)
                if (int'(pix_d) == p)
                    cur_byte = col_q[p][c_sel];
            bit_val = cur_byte[3'd7 - bit_d[2:0]];
            neo_d   = int'(cyc_d) < (bit_val ? T1H_CYC : T0H_CYC);
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cyc_q   <= '0;
            bit_q   <= 5'd0;
            pix_q   <= 3'd0;
            lat_q   <= '0;
            col_q   <= '0;
            neo_q   <= 1'b0;
            rdy_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bit_q   <= bit_d;
            pix_q   <= pix_d;
            lat_q   <= lat_d;
            col_q   <= col_d;
            neo_q   <= neo_d;
            rdy_q   <= rdy_d;
        end
    end

    assign neo_data      = neo_q;
    assign ready_to_load = rdy_q;
    assign ready_to_send = rdy_q;

endmodule

// File: tb/tb_neopixel_driver.sv
// Bench for neopixel_driver: directed sequence with random loads, checked
// cycle by cycle against a frame model built from a byte array.
module tb_neopixel_driver;

    localparam int NP   = 5;
    localparam int T0H  = 18;
    localparam int T1H  = 35;
    localparam int BITC = 63;
    localparam int LATC = 2500;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] pixel_index;
    logic [1:0] color_index;
    logic [7:0] color_level;
    logic       load_color;
    logic       send_it;
    logic       neo_data;
    logic       ready_to_load;
    logic       ready_to_send;

    int cmp_cnt = 0;
    int err_cnt = 0;

    // Reference storage: [pixel][0=R,1=G,2=B]
    logic [7:0] mem [NP][3];

    always #5 clock = ~clock;

    neopixel_driver dut (
        .clock        (clock),
        .reset        (reset),
        .pixel_index  (pixel_index),
        .color_index  (color_index),
        .color_level  (color_level),
        .load_color   (load_color),
        .send_it      (send_it),
        .neo_data     (neo_data),
        .ready_to_load(ready_to_load),
        .ready_to_send(ready_to_send)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp_cnt++;
        assert (obs === exp) else begin
            err_cnt++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        for (int p = 0; p < NP; p++)
            for (int c = 0; c < 3; c++)
                mem[p][c] = 8'h00;
    endtask

    task automatic model_load(input int p, input int c, input int v);
        if (p < NP && c < 3) mem[p][c] = 8'(v);
    endtask

    // Called at a negedge; leaves at the next negedge.
    task automatic do_load(input int p, input int c, input int v);
        pixel_index = 3'(p);
        color_index = 2'(c);
        color_level = 8'(v);
        load_color  = 1'b1;
        model_load(p, c, v);
        @(negedge clock);
        load_color  = 1'b0;
        chk("idle_rdy_load", ready_to_load, 1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        chk("rst_neo", neo_data, 0);
        chk("rst_rdy_send", ready_to_send, 1);
        chk("rst_rdy_load", ready_to_load, 1);
        @(negedge clock);
        reset = 1'b0;
        model_clear();
        @(negedge clock);
    endtask

    // Drives send_it (optionally with a load) at the current negedge, then
    // checks every cycle of the frame and latch gap. abort_at >= 0 asserts
    // reset at that frame cycle; poke injects strobes mid-frame.
    task automatic send_frame(input bit ld, input int lp, input int lc, input int lv,
                              input int abort_at, input bit poke);
        bit bits[$];
        int cidx[3] = '{1, 0, 2};
        int b, c;
        if (ld) begin
            pixel_index = 3'(lp);
            color_index = 2'(lc);
            color_level = 8'(lv);
            load_color  = 1'b1;
            model_load(lp, lc, lv);
        end
        send_it = 1'b1;
        for (int p = 0; p < NP; p++)
            for (int k = 0; k < 3; k++)
                for (int i = 7; i >= 0; i--)
                    bits.push_back(mem[p][cidx[k]][i]);

        for (int k = 0; k < NP * 24 * BITC; k++) begin
            @(negedge clock);
            send_it    = 1'b0;
            load_color = 1'b0;
            if (k == abort_at) begin
                do_reset();
                return;
            end
            b = int'(bits[k / BITC]);
            c = k % BITC;
            chk("neo_bit", neo_data, (c < (b != 0 ? T1H : T0H)) ? 1 : 0);
            chk("send_rdy_send", ready_to_send, 0);
            chk("send_rdy_load", ready_to_load, 0);
            if (poke && k == 100) begin
                pixel_index = 3'd0;
                color_index = 2'd1;
                color_level = 8'h5A;
                load_color  = 1'b1;
            end
            if (poke && k == 200) send_it = 1'b1;
        end
        for (int k = 0; k < LATC; k++) begin
            @(negedge clock);
            chk("latch_neo", neo_data, 0);
            chk("latch_rdy", ready_to_send, 0);
        end
        @(negedge clock);
        chk("end_rdy_send", ready_to_send, 1);
        chk("end_rdy_load", ready_to_load, 1);
        chk("end_neo", neo_data, 0);
`ifdef NEO_CLEAR_AFTER_SEND_EN
        model_clear();
`endif
    endtask

    initial begin
        reset       = 1'b1;
        pixel_index = 3'd0;
        color_index = 2'd0;
        color_level = 8'd0;
        load_color  = 1'b0;
        send_it     = 1'b0;
        model_clear();

        // Reset state
        repeat (2) @(negedge clock);
        chk("por_neo", neo_data, 0);
        chk("por_rdy_send", ready_to_send, 1);
        chk("por_rdy_load", ready_to_load, 1);
        reset = 1'b0;
        @(negedge clock);
        chk("idle_rdy_send", ready_to_send, 1);

        // Out-of-range loads are dropped; frame is all zeros
        do_load(5, 1, 8'hFF);
        do_load(7, 0, 8'hAA);
        do_load(2, 3, 8'hC3);
        do_load(0, 3, 8'hFF);
        send_frame(0, 0, 0, 0, -1, 0);

        // Directed pattern on pixel 0
        do_reset();
        do_load(0, 1, 8'h80);
        do_load(0, 0, 8'h01);
        do_load(0, 2, 8'hFF);
        send_frame(0, 0, 0, 0, -1, 0);

        // Load together with send (pixel 4 blue = 1), mid-frame strobes
        // ignored, then a repeat send of the same stored data
        do_reset();
        for (int i = 0; i < 6; i++)
            do_load(int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 255)));
        send_frame(1, 4, 2, 8'h01, -1, 1);
        send_frame(0, 0, 0, 0, -1, 0);

        // Reset at cycle 3000 of a frame, then a send of all zeros
        for (int i = 0; i < 6; i++)
            do_load(int'($urandom_range(0, 4)), int'($urandom_range(0, 2)),
                    int'($urandom_range(1, 255)));
        send_frame(0, 0, 0, 0, 3000, 0);
        send_frame(0, 0, 0, 0, -1, 0);

        // Random loads, including invalid targets
        for (int i = 0; i < 14; i++)
            do_load(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 255)));
        send_frame(0, 0, 0, 0, -1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

    // Hard stop in case the sequence stalls.
    initial begin
        #2000000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
